// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM frame-buffer bridge: burst geometry, page
// address layout, bridge state and command encodings, and the controller
// timing constants that the bridge and the SDRAM controller both depend on.
// -----------------------------------------------------------------------------
package sdram_pkg;

  // Full-page burst length in 16-bit words.
  localparam int BURST_LEN = 512;

  // Beat counter width. It counts 0 .. BURST_LEN-1 within a burst.
  localparam int BEAT_W = 10;

  // Page address layout: {row[12:0], bank[1:0]}.
  localparam int ROW_W   = 13;
  localparam int BANK_W  = 2;
  localparam int PAGE_AW = ROW_W + BANK_W;

  typedef logic [PAGE_AW-1:0] page_addr_t;
  typedef logic [ROW_W-1:0]   row_t;
  typedef logic [BANK_W-1:0]  bank_t;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_RD_BURST = 2'd3
  } bridge_state_t;

  // Command encoding on the controller rw line.
  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_READ  = 1'b1
  } cmd_t;

  // Controller timing at 165 MHz (in controller clock cycles).
  localparam int CAS_LATENCY = 3;
  localparam int T_RCD_CYC   = 3;    // activate to read/write
  localparam int T_RP_CYC    = 3;    // precharge period
  localparam int T_RFC_CYC   = 11;   // auto-refresh cycle
  localparam int T_REFI_CYC  = 1287; // average refresh interval (7.8 us)

  // Build a page address from its row and bank fields.
  function automatic page_addr_t make_page_addr(input row_t row, input bank_t bank);
    return {row, bank};
  endfunction

  // Row field of a page address.
  function automatic row_t page_row(input page_addr_t addr);
    return addr[PAGE_AW-1:BANK_W];
  endfunction

  // Bank field of a page address.
  function automatic bank_t page_bank(input page_addr_t addr);
    return addr[BANK_W-1:0];
  endfunction

  // Linear page advance with wrap back to the region base after the last page.
  function automatic page_addr_t page_advance(input page_addr_t page,
                                              input page_addr_t base,
                                              input page_addr_t last);
    return (page == last) ? base : page + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock show-ahead FIFO: dout always shows the head word, and a pop
// consumes it. A push into a full FIFO or a pop from an empty one is ignored,
// so the pointers can never be corrupted. count reports the occupancy.
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  // The extra pointer bit tells a full FIFO from an empty one.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !w_empty;

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign count = r_wptr - r_rptr;

  // Storage write.
  // NOTE: the data array has no reset; only the pointers define what is valid,
  // and leaving the array unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  // Pointer update.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_burst_bridge.sv
// -----------------------------------------------------------------------------
// sdram_burst_bridge
// Frame-buffer front end between the pixel pipeline and the SDRAM controller.
// Pixels are buffered in a write FIFO and flushed as full-page write bursts;
// an output FIFO is refilled with full-page read bursts for the display path.
// Page addresses run linearly from each region base and wrap per frame.
//
// Optional build macro: SDRAM_BRIDGE_CHECK_EN
//   When defined, controller beats that would underflow the write FIFO,
//   overflow the output FIFO, or arrive outside a burst are dropped and set
//   the sticky overflow_err flag. When undefined, overflow_err is tied low.
// -----------------------------------------------------------------------------
module sdram_burst_bridge
  import sdram_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 1024,
  parameter int         BURST_LEN    = sdram_pkg::BURST_LEN,
  parameter int         FRAME_BURSTS = 600,
  parameter page_addr_t RD_BASE      = '0,
  parameter page_addr_t WR_BASE      = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  // Upstream pixel stream
  input  logic [15:0]  wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  // Downstream display stream
  output logic [15:0]  rd_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  // SDRAM controller handshake
  output logic         rw,
  output logic         rw_en,
  output logic [14:0]  f_addr,
  output logic [15:0]  f2s_data,
  input  logic         f2s_data_valid,
  input  logic [15:0]  s2f_data,
  input  logic         s2f_data_valid,
  input  logic         ready,
  // Status
  output logic         frame_written,
  output logic         overflow_err
);

  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam page_addr_t WR_LAST = WR_BASE + page_addr_t'(FRAME_BURSTS - 1);
  localparam page_addr_t RD_LAST = RD_BASE + page_addr_t'(FRAME_BURSTS - 1);

  bridge_state_t       r_state;
  cmd_t                r_op;
  logic                r_rw;
  logic                r_rw_en;
  page_addr_t          r_f_addr;
  logic [BEAT_W-1:0]   r_beat_ctr;
  page_addr_t          r_wr_page;
  page_addr_t          r_rd_page;
  logic                r_last_was_read;
  logic                r_frame_written;
  logic                r_alive;

  logic [CW-1:0]       w_wcount;
  logic [CW-1:0]       w_rcount;
  logic                w_wpush;
  logic                w_rpop;
  logic                w_wbeat;
  logic                w_rbeat;
  logic                w_wr_elig;
  logic                w_rd_elig;
  logic                w_beat_last;
  cmd_t                w_pick;

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  assign w_wpush = wr_valid && wr_ready;
  assign w_rpop  = rd_valid && rd_ready;

  sync_fifo_fwft #(
    .DW    (16),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_wpush),
    .din   (wr_data),
    .pop   (w_wbeat),
    .dout  (f2s_data),
    .count (w_wcount)
  );

  sync_fifo_fwft #(
    .DW    (16),
    .DEPTH (FIFO_DEPTH)
  ) u_rfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_rbeat),
    .din   (s2f_data),
    .pop   (w_rpop),
    .dout  (rd_data),
    .count (w_rcount)
  );

  // wr_ready is held low in reset and for the first edge after release.
  assign wr_ready = r_alive && (w_wcount != CW'(FIFO_DEPTH));
  assign rd_valid = (w_rcount != '0);

  // ---------------------------------------------------------------------------
  // Controller beat acceptance and optional protocol checking
  // ---------------------------------------------------------------------------
`ifdef SDRAM_BRIDGE_CHECK_EN
  logic w_cmd_phase;
  logic w_wr_viol;
  logic w_rd_viol;
  logic r_overflow_err;

  assign w_cmd_phase = (r_state == ST_IDLE) || (r_state == ST_ISSUE);
  assign w_wbeat     = f2s_data_valid && (r_state == ST_WR_BURST) && (w_wcount != '0);
  assign w_rbeat     = s2f_data_valid && (r_state == ST_RD_BURST) &&
                       (w_rcount != CW'(FIFO_DEPTH));
  assign w_wr_viol   = f2s_data_valid && (w_cmd_phase || (w_wcount == '0));
  assign w_rd_viol   = s2f_data_valid && (w_cmd_phase || (w_rcount == CW'(FIFO_DEPTH)));

  // Sticky flag for any dropped controller beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow_err <= 1'b0;
    end else if (w_wr_viol || w_rd_viol) begin
      r_overflow_err <= 1'b1;
    end
  end

  assign overflow_err = r_overflow_err;
`else
  assign w_wbeat      = f2s_data_valid && (r_state == ST_WR_BURST);
  assign w_rbeat      = s2f_data_valid && (r_state == ST_RD_BURST);
  assign overflow_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign w_wr_elig   = (w_wcount >= CW'(BURST_LEN));
  assign w_rd_elig   = r_frame_written &&
                       ((CW'(FIFO_DEPTH) - w_rcount) >= CW'(BURST_LEN));
  assign w_beat_last = (r_beat_ctr == BEAT_W'(BURST_LEN - 1));

  // Round-robin pick: a read wins only if the write is not eligible or the
  // previous burst was a write.
  always_comb begin
    w_pick = CMD_WRITE;
    if (w_rd_elig && (!w_wr_elig || !r_last_was_read)) begin
      w_pick = CMD_READ;
    end
  end

  // Marks the first clock edge after reset release so wr_ready rises then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // Sequencer: choose an op, issue a one-cycle request, count the burst beats
  // and advance the page counters when a burst completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_op            <= CMD_WRITE;
      r_rw            <= 1'b0;
      r_rw_en         <= 1'b0;
      r_f_addr        <= '0;
      r_beat_ctr      <= '0;
      r_wr_page       <= WR_BASE;
      r_rd_page       <= RD_BASE;
      r_last_was_read <= 1'b1;
      r_frame_written <= 1'b0;
    end else begin
      r_rw_en <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (ready && (w_wr_elig || w_rd_elig)) begin
            r_state         <= ST_ISSUE;
            r_op            <= w_pick;
            r_rw            <= (w_pick == CMD_READ);
            r_rw_en         <= 1'b1;
            r_f_addr        <= (w_pick == CMD_READ) ? r_rd_page : r_wr_page;
            r_last_was_read <= (w_pick == CMD_READ);
            r_beat_ctr      <= '0;
          end
        end
        ST_ISSUE: begin
          r_state <= (r_op == CMD_READ) ? ST_RD_BURST : ST_WR_BURST;
        end
        ST_WR_BURST: begin
          if (w_wbeat) begin
            if (w_beat_last) begin
              r_beat_ctr <= '0;
              r_wr_page  <= page_advance(r_wr_page, WR_BASE, WR_LAST);
              if (r_wr_page == WR_LAST) r_frame_written <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_beat_ctr <= r_beat_ctr + 1'b1;
            end
          end
        end
        ST_RD_BURST: begin
          if (w_rbeat) begin
            if (w_beat_last) begin
              r_beat_ctr <= '0;
              r_rd_page  <= page_advance(r_rd_page, RD_BASE, RD_LAST);
              r_state    <= ST_IDLE;
            end else begin
              r_beat_ctr <= r_beat_ctr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rw            = r_rw;
  assign rw_en         = r_rw_en;
  assign f_addr        = r_f_addr;
  assign frame_written = r_frame_written;

endmodule

// File: doc/sdram_burst_bridge.md
Name: sdram_burst_bridge

Overview:
- Frame-buffer front end between the pixel pipeline and the SDRAM controller.
- Buffers the incoming pixel stream in a write FIFO. When one full page (512 words) is available, issues a full-page write burst.
- Refills an output FIFO with full-page read bursts for the display/Sobel stage.
- Generates the controller's rw/rw_en/f_addr handshake and linear page addressing with frame wrap.

Parameters:
- FIFO_DEPTH, 1024, words per FIFO (power of two, ≥ 2×BURST_LEN).
- BURST_LEN, 512, words per burst; fixed by full-page mode.
- FRAME_BURSTS, 600, pages per frame (e.g. 640×480 → 600); page address wraps here.
- RD_BASE, 0, first page address of the read region (15 bits).
- WR_BASE, 0, first page address of the write region (15 bits).

Ports:
- clk  in  1  controller clock (165 MHz)
- rst_n  in  1  asynchronous active-low reset
- wr_data  in  16  pixel word from upstream
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  write FIFO not full
- rd_data  out  16  output FIFO head (show-ahead)
- rd_valid  out  1  output FIFO not empty
- rd_ready  in  1  consumer pops on rd_valid&rd_ready
- rw  out  1  to controller; 1 = read, 0 = write
- rw_en  out  1  to controller; one-cycle burst request
- f_addr  out  15  to controller; {row[12:0], bank[1:0]} = page address
- f2s_data  out  16  to controller; write FIFO head, combinational
- f2s_data_valid  in  1  from controller; pop write FIFO this cycle
- s2f_data  in  16  from controller
- s2f_data_valid  in  1  from controller; push s2f_data into output FIFO
- ready  in  1  from controller; idle and accepting a request
- frame_written  out  1  sticky; first full frame stored
- overflow_err  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset: all FIFOs empty, page counters at base, FSM IDLE, rw_en=0, rw=0, f_addr=0, wr_ready=0 (becomes 1 the cycle after reset release), rd_valid=0, frame_written=0, overflow_err=0.
- FSM states: IDLE, ISSUE, WR_BURST, RD_BURST.
- Eligibility:
  - wr_elig = wfifo_count ≥ BURST_LEN.
  - rd_elig = frame_written && (FIFO_DEPTH − rfifo_count) ≥ BURST_LEN.
- IDLE:
  - If ready && (wr_elig || rd_elig), go to ISSUE.
  - If both are eligible, round-robin via a last_was_read flag; after reset the write wins.
- ISSUE, one cycle:
  - rw_en=1; rw=op; f_addr=current page counter of that op.
  - Next state WR_BURST or RD_BURST.
  - rw_en is never high for more than one cycle.
- WR_BURST:
  - f2s_data always equals the write FIFO head, so the word is valid before the edge at which f2s_data_valid is high.
  - Pop on each f2s_data_valid and increment beat_ctr (10 bits).
  - At beat 512: wr_page increments, wrapping to WR_BASE after FRAME_BURSTS pages; go to IDLE.
  - On the first write wrap, set frame_written.
- RD_BURST:
  - Push s2f_data on each s2f_data_valid and count beats.
  - At beat 512: rd_page advances with the same wrap rule; go to IDLE.
- IDLE waits for ready to reassert. Ready is low during the controller's precharge/refresh, so no extra delay counter is needed here.
- The upstream write stream continues during every state. wr_ready=!wfifo_full. Simultaneous push and pop in the same cycle leaves the count unchanged.
- Output FIFO: rd_valid=!empty; simultaneous push and pop are legal.
- Eligibility guarantees no overflow and no underflow by construction, because the controller cannot be stalled.
- Reset mid-burst aborts the burst. The bridge and controller share rst_n, so both restart and the lost partial page is accepted.
- Counts are width log2(FIFO_DEPTH)+1. Page arithmetic is 15-bit: compare against FRAME_BURSTS−1, then load base.

Optional Feature:
- Macro: SDRAM_BRIDGE_CHECK_EN.
- Defined:
  - overflow_err sets sticky on any of: f2s_data_valid with the write FIFO empty; s2f_data_valid with the output FIFO full; a beat arriving in IDLE/ISSUE.
  - Each offending beat is dropped, with no pointer corruption.
- Undefined: overflow_err tied 0 and no checking logic is built; these protocol violations are then undefined.

Decomposition:
- Shared package sdram_pkg:
  - BURST_LEN.
  - Command/state encodings.
  - Page address width (15) and the row/bank split.
  - The shared controller timing constants.
- One sub-module, sync_fifo_fwft: single-clock show-ahead FIFO with count output. It is instantiated twice, for the write and output FIFOs.

Test Plan:
- Push 512 words (0..511) with rd_ready=0 → exactly one rw_en pulse with rw=0, f_addr=WR_BASE. With a controller model, 512 f2s_data_valid beats present 0..511 in order. wfifo_count returns to 0.
- Write FRAME_BURSTS=4 (test value) pages → frame_written rises after the 4th burst, and the 5th write uses f_addr=WR_BASE again (wrap).
- After frame_written, with rd_ready=1 → read burst issued with rw=1, f_addr=RD_BASE. 512 s2f beats of value 0xA000+i appear on rd_data in order.
- Both eligible while ready is held high → alternating write, read, write, read requests, with the first being a write after reset.
- Output FIFO at 600 of 1024 words with rd_ready=0 → no read is issued (424 free < 512). After popping 88 words, a read is issued.
- Assert rst_n=0 in the middle of a write burst (beat 200) → all outputs take reset values immediately. After release, the first request again uses WR_BASE. With SDRAM_BRIDGE_CHECK_EN, inject f2s_data_valid in IDLE → overflow_err=1 and stays set.
